pipe_skid_buffer: RTL and testbench

Two-entry valid/ready skid buffer between adjacent pipeline stages of the MIPS datapath. It is the consumer-side counterpart to the stage-delay register. It accepts 32-bit words from an upstream stage and presents them to a downstream stage with a registered one-cycle latency. It absorbs one extra word when the downstream stalls, so upstream ready is fully registered. A synchronous flush discards all buffered words on branch/jump redirect.

---
 rtl/pipe_skid_buffer.sv | 156 +++++++++++++++
 tb/tb_pipe_skid_buffer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer
//
// Two-entry valid/ready skid buffer placed between adjacent MIPS pipeline
// stages. Words from the upstream stage are presented downstream one cycle
// after acceptance, from a registered output. When the downstream stage
// stalls, one extra word is parked in a skid register. Because of this,
// in_ready depends only on local state and is driven from a flop. A
// synchronous flush drops every buffered word on a branch/jump redirect.
//
// Optional feature macro: SKID_STALL_CNT_EN adds the stall_cnt output and
// its saturating counter.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous discard of all buffered words (highest priority)
//   in_data    upstream word
//   in_valid   upstream word valid
//   in_ready   buffer can accept a word this cycle (registered)
//   out_data   downstream word (registered)
//   out_valid  out_data valid (registered)
//   out_ready  downstream accepts out_data this cycle
//   stall_cnt  saturating count of downstream stall cycles
//              (present only with SKID_STALL_CNT_EN)

module pipe_skid_buffer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef SKID_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic              valid_q;
  logic              ready_q;
  logic              in_fire;
  logic              out_fire;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid;

  assign in_fire  = in_valid & ready_q;
  assign out_fire = valid_q & out_ready;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      // Redirect: whatever is buffered or arriving this cycle is dropped.
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            load_main_in = 1'b1;
            state_nxt    = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            load_skid = 1'b1;
            state_nxt = FULL;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain path can move.
          if (out_fire) begin
            load_main_skid = 1'b1;
            state_nxt      = BUSY;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Control registers. ready_q comes out of reset low and rises on the first
  // edge, which produces the one-cycle start-up bubble with no extra flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      valid_q <= (state_nxt != EMPTY);
      ready_q <= (state_nxt != FULL);
    end
  end

  // The main register drives out_data, which must read zero in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data <= '0;
    end else if (load_main_in) begin
      main_data <= in_data;
    end else if (load_main_skid) begin
      main_data <= skid_data;
    end
  end

  // The skid register is never observed before it is written, so it has
  // no reset.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_data <= in_data;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_data  = main_data;

`ifdef SKID_STALL_CNT_EN
  logic [15:0] stall_q;

  // Counts edges where a valid word is held back by downstream. Flush does
  // not clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 16'h0000;
    end else if (valid_q && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'h0001;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Testbench for pipe_skid_buffer: directed vector table, hand-written
// stream / reset sequences, and randomized traffic compared against a
// queue-based model of a two-word FIFO with registered ready.

module tb_pipe_skid_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
`ifdef SKID_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  pipe_skid_buffer #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef SKID_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        eov;
    logic [31:0] eod;
    logic        eir;
    int          est;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [31:0] d, input logic ordy);
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    #1;
  endtask

  // Reference model: the buffer is a FIFO of at most two words.
  logic [31:0] mq[$];
  logic        m_ir;
  int          m_stall;

  task automatic model_reset();
    mq.delete();
    m_ir    = 1'b0;
    m_stall = 0;
  endtask

  // Called with the inputs that are present just before a rising edge.
  task automatic model_edge(input logic fl, input logic iv, input logic [31:0] d, input logic ordy);
    bit in_fire, out_fire;
    in_fire  = iv && m_ir;
    out_fire = (mq.size() > 0) && ordy;
    if ((mq.size() > 0) && !ordy && (m_stall < 65535)) m_stall++;
    if (fl) begin
      mq.delete();
    end else begin
      if (out_fire) void'(mq.pop_front());
      if (in_fire) mq.push_back(d);
    end
    m_ir = (mq.size() < 2);
  endtask

  task automatic model_compare(input string tag);
    chk({tag, "_out_valid"}, {31'b0, out_valid}, {31'b0, mq.size() > 0});
    chk({tag, "_in_ready"}, {31'b0, in_ready}, {31'b0, m_ir});
    if (mq.size() > 0) chk({tag, "_out_data"}, out_data, mq[0]);
`ifdef SKID_STALL_CNT_EN
    chk({tag, "_stall_cnt"}, {16'b0, stall_cnt}, m_stall);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0);

    // Directed table: reset release, stall/skid/drain, flush cases.
    vecs[0]  = '{1'b0, 1'b1, 32'h00000001, 1'b0, 1'b0, 32'h0,        1'b1, 0};
    vecs[1]  = '{1'b0, 1'b1, 32'h00000001, 1'b0, 1'b1, 32'h00000001, 1'b1, 0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 0};
    vecs[3]  = '{1'b0, 1'b1, 32'h000000A0, 1'b0, 1'b1, 32'h000000A0, 1'b1, 0};
    vecs[4]  = '{1'b0, 1'b1, 32'h000000A1, 1'b0, 1'b1, 32'h000000A0, 1'b0, 1};
    vecs[5]  = '{1'b0, 1'b1, 32'h000000A2, 1'b0, 1'b1, 32'h000000A0, 1'b0, 2};
    vecs[6]  = '{1'b0, 1'b1, 32'h000000A2, 1'b1, 1'b1, 32'h000000A1, 1'b1, 2};
    vecs[7]  = '{1'b0, 1'b1, 32'h000000A2, 1'b1, 1'b1, 32'h000000A2, 1'b1, 2};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 2};
    vecs[9]  = '{1'b0, 1'b1, 32'h000000B0, 1'b0, 1'b1, 32'h000000B0, 1'b1, 2};
    vecs[10] = '{1'b0, 1'b1, 32'h000000B1, 1'b0, 1'b1, 32'h000000B0, 1'b0, 3};
    vecs[11] = '{1'b1, 1'b1, 32'h000000FF, 1'b0, 1'b0, 32'h0,        1'b1, 4};
    vecs[12] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 4};
    vecs[13] = '{1'b0, 1'b1, 32'h000000C0, 1'b0, 1'b1, 32'h000000C0, 1'b1, 4};
    vecs[14] = '{1'b1, 1'b1, 32'h000000EE, 1'b1, 1'b0, 32'h0,        1'b1, 4};

    // Reset values, observed with no clock edge after release.
    #12;
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
`ifdef SKID_STALL_CNT_EN
    chk("rst_stall_cnt", {16'b0, stall_cnt}, 32'd0);
`endif

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      tick();
      chk($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].eov});
      chk($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].eir});
      if (vecs[i].eov) chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].eod);
`ifdef SKID_STALL_CNT_EN
      chk($sformatf("vec%0d_stall_cnt", i), {16'b0, stall_cnt}, vecs[i].est);
`endif
      if (i == 12) begin
        total_cnt++;
        if (out_data !== 32'hFF) pass_cnt++;
        else $display("FAIL flush_leak: got out_data 0x%08h, required anything but 0x000000ff", out_data);
      end
    end

    // Stream 0x10..0x1F with downstream always ready.
    for (int w = 'h10; w <= 'h1F; w++) begin
      drive(1'b0, 1'b1, 32'(w), 1'b1);
      tick();
      chk($sformatf("stream%0h_out_valid", w), {31'b0, out_valid}, 32'd1);
      chk($sformatf("stream%0h_out_data", w), out_data, 32'(w));
      chk($sformatf("stream%0h_in_ready", w), {31'b0, in_ready}, 32'd1);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    chk("stream_end_out_valid", {31'b0, out_valid}, 32'd0);
`ifdef SKID_STALL_CNT_EN
    chk("stream_stall_cnt", {16'b0, stall_cnt}, 32'd4);
`endif

    // Asynchronous reset while FULL.
    drive(1'b0, 1'b1, 32'h55, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h66, 1'b0);
    tick();
    chk("pre_arst_in_ready", {31'b0, in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_out_data", out_data, 32'd0);
    chk("arst_in_ready", {31'b0, in_ready}, 32'd0);
`ifdef SKID_STALL_CNT_EN
    chk("arst_stall_cnt", {16'b0, stall_cnt}, 32'd0);
`endif

    // Randomized traffic against the FIFO model.
    do_reset();
    model_reset();
    model_compare("rnd_init");
    for (int c = 0; c < 3000; c++) begin
      logic fl, iv, ordy;
      logic [31:0] d;
      fl   = ($urandom_range(0, 39) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      d    = $urandom;
      drive(fl, iv, d, ordy);
      model_edge(fl, iv, d, ordy);
      tick();
      model_compare($sformatf("rnd%0d", c));
    end

`ifdef SKID_STALL_CNT_EN
    // Saturation of the stall counter.
    do_reset();
    drive(1'b0, 1'b1, 32'h77, 1'b0);
    tick();
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    for (int c = 0; c < 70000; c++) begin
      @(posedge clk);
    end
    #1;
    chk("sat_stall_cnt", {16'b0, stall_cnt}, 32'h0000FFFF);
    chk("sat_out_data", out_data, 32'h77);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
